pixel_raster_gen: RTL and testbench
===================================

# pixel_raster_gen

- Raster sequencer that sits directly upstream of the RGB-to-32-bit packer.
- Walks pixel coordinates (x, y) across an H_RES × V_RES frame and presents them to the shading logic.
- Captures the returned colour into a registered output stage and drives the packer's pixel interface (r, g, b, valid, sof, eol) under a valid/ready handshake.
- Frames are launched by an enable, counted, and always complete once started.

## Interface
- H_RES, 640: pixels per line. ≥ 2, and H_RES·3 must be a multiple of 4 so the packer ends each line word-aligned.
- V_RES, 480: lines per frame. ≥ 1.
- CW, 11: coordinate width. Requires H_RES ≤ 2^CW and V_RES ≤ 2^CW.
- Clock and reset: one clock, `aclk`. Reset `areset` is synchronous and active-high.
- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- en  in  1  run request, sampled only at frame boundaries.
- x  out  CW  current column sent to the shader.
- y  out  CW  current line sent to the shader.
- r_in  in  8  shader colour for (x, y), valid in the same cycle.
- g_in  in  8  shader colour for (x, y), valid in the same cycle.
- b_in  in  8  shader colour for (x, y), valid in the same cycle.
- r  out  8  registered pixel to the packer.
- g  out  8  registered pixel to the packer.
- b  out  8  registered pixel to the packer.
- valid  out  1  pixel on r/g/b is valid.
- sof  out  1  pixel is (0, 0).
- eol  out  1  pixel is the last of its line.
- ready  in  1  packer accepts the pixel this cycle (its in_stream_ready).
- busy  out  1  state == RUN or valid == 1.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.
- frame_count  out  16  frames completed; wraps modulo 2^16.

## Operation
**States**
- Two states: IDLE and RUN.
- IDLE → RUN when en = 1; x and y are already 0.
- RUN → IDLE at the edge that loads pixel (H_RES−1, V_RES−1) if en = 0 at that edge.
- Otherwise RUN continues straight into the next frame with no gap.

**Load**
- load = (state == RUN) & (!valid | ready).
- On load:
  - r/g/b ← r_in/g_in/b_in.
  - sof ← (x == 0 & y == 0).
  - eol ← (x == H_RES−1).
  - valid ← 1.
- Coordinate advance on load:
  - x increments. At H_RES−1, x wraps to 0 and y increments.
  - At (H_RES−1, V_RES−1), both x and y wrap to 0.
- When not loading and (valid & ready): valid ← 0.

**Stall**
- When valid & !ready: r, g, b, sof, eol, x and y all hold.
- No pixel is dropped or duplicated.

**Frame completion**
- frame_done = 1 for exactly the cycle in which valid & ready & eol & (the pixel is from line V_RES−1).
- frame_count increments at that same edge.
- Track "last line" with a registered flag captured at load.

**en handling**
- en is ignored mid-frame.
- Deasserting en mid-frame finishes the frame, then returns to IDLE.

**Reset values**
- state = IDLE; x = y = 0; valid = sof = eol = 0; r = g = b = 0; frame_done = 0; frame_count = 0; busy = 0.

**Reset mid-frame**
- All of the above takes effect at the next edge, regardless of stall.
- The next frame starts at sof.

## Timing
- Edge N: en = 1 sampled in IDLE → state = RUN.
- Edge N+1: first pixel loaded; valid = 1 from N+1.
- Throughput is 1 pixel/cycle while ready = 1.
- Pixel latency from (x, y) presentation to the output register is 1 cycle.
- The shader colour path must be combinational from x/y within the cycle.
- The packer's ready is combinational from its own state and sof. This block does not combinationally depend on ready for valid/data; only the load enable uses ready.

## Configuration
- Macro: `PIXEL_RASTER_TEST_PATTERN_EN`.
- Defined: r_in/g_in/b_in are ignored. Loaded colour is r = x[7:0], g = y[7:0], b = x[7:0] ^ y[7:0]. Used for bring-up without the shader.
- Undefined: colour comes from r_in/g_in/b_in as described.

## Test plan
All scenarios use H_RES = 8, V_RES = 2 unless stated.

1. **Single frame, no stall.** Reset, ready = 1, en = 1 for one frame.
   - 16 consecutive valid beats.
   - sof on beat 0 only; eol on beats 7 and 15.
   - frame_done high only on beat 15; frame_count = 1.
   - Returns to IDLE when en = 0.
2. **Backpressure.** Shader returns r = x, g = y, b = 0xA5. ready pattern 1,0,0,1,0,1…
   - Accepted sequence is exactly (0,0)…(7,1) in order.
   - Outputs stable during every ready = 0 cycle.
3. **en dropped mid-frame.** en falls at beat 5.
   - All 16 beats still delivered.
   - valid = 0 afterwards; busy = 0 one cycle after the last acceptance.
4. **Continuous run.** en held high for 3 frames, ready = 1.
   - 48 back-to-back beats; sof on beats 0, 16, 32.
   - frame_count = 3; no idle cycle between frames.
5. **Reset mid-frame.** Reset asserted at beat 10 with ready = 0.
   - Next cycle: valid = 0, frame_count = 0, x = y = 0.
   - Re-enabling produces sof at (0, 0).
6. **Test pattern.** With `PIXEL_RASTER_TEST_PATTERN_EN` and r_in = 0xFF, pixel (5, 1) is emitted as r = 0x05, g = 0x01, b = 0x04.

Source files
------------

// File: rtl/pixel_raster_gen.sv
// rtl/pixel_raster_gen.sv - raster (x, y) walker with a registered valid/ready pixel stage
// Build option: PIXEL_RASTER_TEST_PATTERN_EN replaces shader colour with a coordinate pattern.
module pixel_raster_gen #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CW    = 11
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic [7:0]    b_in,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          valid,
  output logic          sof,
  output logic          eol,
  input  logic          ready,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]    r_q, g_q, b_q;
  logic [7:0]    r_sel, g_sel, b_sel;
  logic          valid_q, sof_q, eol_q, last_line_q;
  logic [15:0]   frame_count_q;
  logic          load, x_last, y_last, accept_last;

  assign x_last      = (x_q == CW'(H_RES - 1));
  assign y_last      = (y_q == CW'(V_RES - 1));
  assign load        = (state_q == RUN) && (!valid_q || ready);
  assign accept_last = valid_q && ready && eol_q && last_line_q;

`ifdef PIXEL_RASTER_TEST_PATTERN_EN
  logic unused_shader;
  assign unused_shader = ^{r_in, g_in, b_in};
  assign r_sel = 8'(x_q);
  assign g_sel = 8'(y_q);
  assign b_sel = 8'(x_q) ^ 8'(y_q);
`else
  assign r_sel = r_in;
  assign g_sel = g_in;
  assign b_sel = b_in;
`endif

  // en is only consulted at frame boundaries: entering from IDLE, or at the last pixel's load.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (load && x_last && y_last && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      last_line_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (load) begin
        r_q         <= r_sel;
        g_q         <= g_sel;
        b_q         <= b_sel;
        sof_q       <= (x_q == '0) && (y_q == '0);
        eol_q       <= x_last;
        last_line_q <= y_last;
        valid_q     <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (accept_last) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign valid       = valid_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign busy        = (state_q == RUN) || valid_q;
  assign frame_done  = accept_last;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_raster_gen.sv
// tb/tb_pixel_raster_gen.sv - directed self-checking bench for pixel_raster_gen (8x2 frame)
module tb_pixel_raster_gen;

  localparam int H  = 8;
  localparam int V  = 2;
  localparam int CW = 11;
  localparam logic [5:0] READY_PAT = 6'b101001;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          en = 1'b0;
  logic          ready = 1'b0;
  logic [CW-1:0] x, y;
  logic [7:0]    r_in, g_in, b_in, r, g, b;
  logic          valid, sof, eol, busy, frame_done;
  logic [15:0]   frame_count;
  int            tests = 0;
  int            fails = 0;

  always #5 aclk = ~aclk;

`ifdef PIXEL_RASTER_TEST_PATTERN_EN
  assign r_in = 8'hFF;
`else
  assign r_in = x[7:0];
`endif
  assign g_in = y[7:0];
  assign b_in = 8'hA5;

  pixel_raster_gen #(.H_RES(H), .V_RES(V), .CW(CW)) dut (
    .aclk(aclk), .areset(areset), .en(en), .x(x), .y(y),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .r(r), .g(g), .b(b),
    .valid(valid), .sof(sof), .eol(eol), .ready(ready), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  // Expected {r, g, b, sof, eol} for the k-th accepted beat since a run began.
  function automatic logic [25:0] exp_beat(input int k);
    logic [7:0] xe, ye, be;
    xe = 8'(k % H);
    ye = 8'((k / H) % V);
`ifdef PIXEL_RASTER_TEST_PATTERN_EN
    be = xe ^ ye;
`else
    be = 8'hA5;
`endif
    return {xe, ye, be, (k % (H * V)) == 0, (k % H) == (H - 1)};
  endfunction

  task automatic test_reset;
    areset = 1'b1; en = 1'b0; ready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    tests++;
    if ({valid, sof, eol, busy, frame_done} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b want 00000", {valid, sof, eol, busy, frame_done});
    end
    tests++;
    if ({r, g, b} !== 24'h0) begin
      fails++; $display("FAIL reset_rgb got %h want 000000", {r, g, b});
    end
    tests++;
    if (x !== 0 || y !== 0 || frame_count !== 16'd0) begin
      fails++; $display("FAIL reset_xy_count got x=%0d y=%0d fc=%0d want 0 0 0", x, y, frame_count);
    end
    areset = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL idle_no_en got valid=%b busy=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_single_frame;
    int beats = 0, first_c = -1, last_c = -1;
    @(negedge aclk); en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk); #1;
      tests++;
      if (frame_done !== (valid && beats == 15)) begin
        fails++; $display("FAIL single_frame_done beat=%0d got %b", beats, frame_done);
      end
      if (valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        tests++;
        if ({r, g, b, sof, eol} !== exp_beat(beats)) begin
          fails++; $display("FAIL single_pix beat=%0d got %h want %h", beats, {r, g, b, sof, eol}, exp_beat(beats));
        end
        beats++;
        en = 1'b0;
      end
    end
    tests++;
    if (first_c !== 1) begin
      fails++; $display("FAIL single_latency got first valid cycle %0d want 1", first_c);
    end
    tests++;
    if (beats !== 16 || (last_c - first_c) !== 15) begin
      fails++; $display("FAIL single_beats got %0d span %0d want 16 span 15", beats, last_c - first_c);
    end
    tests++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL single_end got fc=%0d busy=%b want 1 0", frame_count, busy);
    end
  endtask

  task automatic test_backpressure;
    int beats = 0;
    logic stalled = 1'b0;
    logic [48:0] snap = '0;
    @(negedge aclk); en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk); ready = READY_PAT[c % 6]; #1;
      if (stalled) begin
        tests++;
        if ({r, g, b, sof, eol, valid, x, y} !== snap) begin
          fails++; $display("FAIL bp_hold cycle=%0d got %h want %h", c, {r, g, b, sof, eol, valid, x, y}, snap);
        end
      end
      if (valid && ready) begin
        tests++;
        if ({r, g, b, sof, eol} !== exp_beat(beats) || frame_done !== (beats == 15)) begin
          fails++; $display("FAIL bp_pix beat=%0d got %h fd=%b want %h", beats, {r, g, b, sof, eol}, frame_done, exp_beat(beats));
        end
        beats++;
        en = 1'b0;
      end else begin
        tests++;
        if (frame_done !== 1'b0) begin
          fails++; $display("FAIL bp_frame_done_idle cycle=%0d got 1 want 0", c);
        end
      end
      stalled = valid && !ready;
      snap = {r, g, b, sof, eol, valid, x, y};
    end
    tests++;
    if (beats !== 16 || frame_count !== 16'd2 || busy !== 1'b0) begin
      fails++; $display("FAIL bp_end got beats=%0d fc=%0d busy=%b want 16 2 0", beats, frame_count, busy);
    end
    ready = 1'b1;
  endtask

  task automatic test_en_drop;
    int beats = 0;
    @(negedge aclk); en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 60 && beats < 16; c++) begin
      @(negedge aclk);
      if (beats == 5) en = 1'b0;
      #1;
      if (valid) begin
        tests++;
        if ({r, g, b, sof, eol} !== exp_beat(beats) || frame_done !== (beats == 15)) begin
          fails++; $display("FAIL en_drop_pix beat=%0d got %h fd=%b want %h", beats, {r, g, b, sof, eol}, frame_done, exp_beat(beats));
        end
        beats++;
      end
    end
    @(negedge aclk); #1;
    tests++;
    if (beats !== 16 || valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL en_drop_end got beats=%0d valid=%b busy=%b want 16 0 0", beats, valid, busy);
    end
    tests++;
    if (frame_count !== 16'd3) begin
      fails++; $display("FAIL en_drop_count got %0d want 3", frame_count);
    end
  endtask

  task automatic test_back_to_back;
    int beats = 0, first_c = -1;
    @(negedge aclk); en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 80 && beats < 48; c++) begin
      @(negedge aclk); #1;
      if (first_c >= 0) begin
        tests++;
        if (valid !== 1'b1) begin
          fails++; $display("FAIL b2b_gap beat=%0d got valid=%b want 1", beats, valid);
        end
      end
      if (valid) begin
        if (first_c < 0) first_c = c;
        tests++;
        if ({r, g, b, sof, eol} !== exp_beat(beats) || frame_done !== ((beats % 16) == 15)) begin
          fails++; $display("FAIL b2b_pix beat=%0d got %h fd=%b want %h", beats, {r, g, b, sof, eol}, frame_done, exp_beat(beats));
        end
        beats++;
        if (beats >= 33) en = 1'b0;
      end
    end
    @(negedge aclk); #1;
    tests++;
    if (beats !== 48 || valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_end got beats=%0d valid=%b busy=%b want 48 0 0", beats, valid, busy);
    end
    tests++;
    if (frame_count !== 16'd6) begin
      fails++; $display("FAIL b2b_count got %0d want 6", frame_count);
    end
  endtask

  task automatic test_reset_mid_frame;
    int beats = 0;
    logic hit = 1'b0;
    @(negedge aclk); en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      if (valid && beats == 10) begin
        ready = 1'b0; areset = 1'b1; en = 1'b0; hit = 1'b1;
        break;
      end
      #1;
      if (valid) beats++;
    end
    tests++;
    if (hit !== 1'b1) begin
      fails++; $display("FAIL rst_mid_reach got beats=%0d want 10", beats);
    end
    @(negedge aclk); #1;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 || x !== 0 || y !== 0) begin
      fails++; $display("FAIL rst_mid_state got valid=%b busy=%b fc=%0d x=%0d y=%0d want 0 0 0 0 0", valid, busy, frame_count, x, y);
    end
    areset = 1'b0; en = 1'b1; ready = 1'b1;
    @(negedge aclk); #1;
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL rst_mid_restart_latency got valid=%b want 0", valid);
    end
    @(negedge aclk); #1;
    tests++;
    if (valid !== 1'b1 || {r, g, b, sof, eol} !== exp_beat(0)) begin
      fails++; $display("FAIL rst_mid_sof got valid=%b %h want 1 %h", valid, {r, g, b, sof, eol}, exp_beat(0));
    end
    en = 1'b0;
    beats = valid ? 1 : 0;
    for (int c = 0; c < 40 && beats < 16; c++) begin
      @(negedge aclk); #1;
      if (valid) beats++;
    end
    @(negedge aclk); #1;
    tests++;
    if (beats !== 16 || frame_count !== 16'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_drain got beats=%0d fc=%0d busy=%b want 16 1 0", beats, frame_count, busy);
    end
  endtask

`ifdef PIXEL_RASTER_TEST_PATTERN_EN
  task automatic test_pattern;
    int beats = 0;
    logic seen = 1'b0;
    @(negedge aclk); en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 40 && beats < 16; c++) begin
      @(negedge aclk); #1;
      if (valid) begin
        if (beats == 13) begin
          seen = 1'b1;
          tests++;
          if ({r, g, b} !== 24'h050104) begin
            fails++; $display("FAIL pattern_5_1 got %h want 050104", {r, g, b});
          end
        end
        beats++;
        en = 1'b0;
      end
    end
    tests++;
    if (seen !== 1'b1) begin
      fails++; $display("FAIL pattern_reach got beats=%0d want 16", beats);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_backpressure;
    test_en_drop;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef PIXEL_RASTER_TEST_PATTERN_EN
    test_pattern;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
